// File: rtl/branch_unit.sv
// EX-stage branch/jump resolution: compare, target/link generation, mispredict
// detection, one valid/ready result register and saturating statistics counters.
module branch_unit #(
    parameter int DATAW = 32,
    parameter int CNTW  = 16,
    parameter int ILEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       kind,
    input  logic [2:0]       cmp_type,    // funct3 compare code ("type" is a reserved word)
    input  logic [DATAW-1:0] a,
    input  logic [DATAW-1:0] b,
    input  logic [DATAW-1:0] pc,
    input  logic [DATAW-1:0] imm,
    input  logic             pred_taken,
    input  logic [DATAW-1:0] pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [DATAW-1:0] target,
    output logic [DATAW-1:0] link,
    output logic             redirect,
    output logic [DATAW-1:0] redirect_pc,
    output logic             illegal,
    output logic [CNTW-1:0]  br_cnt,
    output logic [CNTW-1:0]  mis_cnt,
    input  logic             cnt_clr
);

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JAL    = 2'b10;
    localparam logic [1:0] KIND_JALR   = 2'b11;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
    endfunction

    logic             valid_r, taken_r, redirect_r, illegal_r, cf_r;
    logic [DATAW-1:0] target_r, link_r, redirect_pc_r;
    logic [CNTW-1:0]  br_cnt_r, mis_cnt_r;

    logic             taken_s, illegal_s, redirect_s, eq_s, lt_s, ltu_s;
    logic [DATAW-1:0] pc_tgt_s, reg_sum_s, target_s, link_s, redirect_pc_s;
    logic             accept_s, fire_s, ready_s;

    assign eq_s      = (a == b);
    assign lt_s      = ($signed(a) < $signed(b));
    assign ltu_s     = (a < b);
    assign pc_tgt_s  = pc + imm;
    assign reg_sum_s = a + imm;
    assign link_s    = pc + DATAW'(ILEN);

    // Resolve direction and legality of the incoming instruction
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (kind)
            KIND_BRANCH: begin
                case (cmp_type)
                    3'b000:  taken_s = eq_s;
                    3'b001:  taken_s = !eq_s;
                    3'b100:  taken_s = lt_s;
                    3'b101:  taken_s = !lt_s;
                    3'b110:  taken_s = ltu_s;
                    3'b111:  taken_s = !ltu_s;
                    default: illegal_s = 1'b1;
                endcase
            end
            KIND_JAL:  taken_s = 1'b1;
            KIND_JALR: taken_s = 1'b1;
            default: begin
                taken_s   = 1'b0;
                illegal_s = 1'b0;
            end
        endcase
    end

    // Target, next PC and mispredict decision
    always_comb begin
        target_s = pc_tgt_s;
        if (kind == KIND_JALR) begin
            target_s = {reg_sum_s[DATAW-1:1], 1'b0};
        end else begin
            target_s = pc_tgt_s;
        end
        redirect_pc_s = taken_s ? target_s : link_s;
        redirect_s    = (kind != KIND_NONE) &&
                        ((taken_s != pred_taken) || (taken_s && (target_s != pred_target)));
    end

    assign ready_s  = !valid_r || out_ready;
    assign accept_s = in_valid && ready_s && !flush;
    assign fire_s   = valid_r && out_ready && !flush;

    // Output-register occupancy; flush kills both the held and the incoming beat
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
        end else if (fire_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Result payload, loaded only on accept so it stays stable under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_r       <= 1'b0;
            target_r      <= '0;
            link_r        <= '0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= '0;
            illegal_r     <= 1'b0;
            cf_r          <= 1'b0;
        end else if (accept_s) begin
            taken_r       <= taken_s;
            target_r      <= target_s;
            link_r        <= link_s;
            redirect_r    <= redirect_s;
            redirect_pc_r <= redirect_pc_s;
            illegal_r     <= illegal_s;
            cf_r          <= (kind != KIND_NONE);
        end else begin
            taken_r       <= taken_r;
            target_r      <= target_r;
            link_r        <= link_r;
            redirect_r    <= redirect_r;
            redirect_pc_r <= redirect_pc_r;
            illegal_r     <= illegal_r;
            cf_r          <= cf_r;
        end
    end

    // Saturating statistics, counted when a control-flow result leaves the unit
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_r  <= '0;
            mis_cnt_r <= '0;
        end else if (cnt_clr) begin
            br_cnt_r  <= '0;
            mis_cnt_r <= '0;
        end else if (fire_s && cf_r) begin
            br_cnt_r  <= sat_inc(br_cnt_r);
            mis_cnt_r <= redirect_r ? sat_inc(mis_cnt_r) : mis_cnt_r;
        end else begin
            br_cnt_r  <= br_cnt_r;
            mis_cnt_r <= mis_cnt_r;
        end
    end

    assign in_ready    = ready_s;
    assign out_valid   = valid_r;
    assign taken       = taken_r;
    assign target      = target_r;
    assign link        = link_r;
    assign redirect    = redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign illegal     = illegal_r;
    assign br_cnt      = br_cnt_r;
    assign mis_cnt     = mis_cnt_r;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized traffic
// checked against an arithmetic reference model with 4-bit counters.
module tb_branch_unit;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, pred_taken, out_valid, out_ready;
    logic          taken, redirect, illegal, cnt_clr;
    logic [1:0]    kind;
    logic [2:0]    cmp_type;
    logic [DW-1:0] a, b, pc, imm, pred_target, target, link, redirect_pc;
    logic [CW-1:0] br_cnt, mis_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          taken;
        bit [31:0]   target;
        bit [31:0]   link;
        bit          redirect;
        bit [31:0]   rpc;
        bit          illegal;
        bit          cf;
    } res_t;

    bit   mv;
    res_t mres;
    int   mbr, mmis;

    branch_unit #(.DATAW(DW), .CNTW(CW), .ILEN(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .cmp_type(cmp_type), .a(a), .b(b), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_target(pred_target), .out_valid(out_valid),
        .out_ready(out_ready), .taken(taken), .target(target), .link(link),
        .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t ref_model(input bit [1:0] k, input bit [2:0] t,
                                       input bit [31:0] ra, input bit [31:0] rb,
                                       input bit [31:0] rpc, input bit [31:0] rimm,
                                       input bit pt, input bit [31:0] ptg);
        res_t r;
        longint unsigned m = 64'h1_0000_0000;
        longint unsigned ua = ra, ub = rb, up = rpc, ui = rimm, s;
        int sa = ra;
        int sb = rb;
        r = '{default: 0};
        r.cf   = (k != 0);
        r.link = 32'((up + 4) % m);
        if (k == 3) begin
            s = (ua + ui) % m;
            r.target = 32'(s - (s % 2));
        end else begin
            r.target = 32'((up + ui) % m);
        end
        if (k == 1) begin
            if      (t == 0) r.taken = (ua == ub);
            else if (t == 1) r.taken = (ua != ub);
            else if (t == 4) r.taken = (sa < sb);
            else if (t == 5) r.taken = (sa >= sb);
            else if (t == 6) r.taken = (ua < ub);
            else if (t == 7) r.taken = (ua >= ub);
            else r.illegal = 1;
        end else begin
            r.taken = (k >= 2);
        end
        r.rpc = r.taken ? r.target : r.link;
        r.redirect = (k != 0) && ((r.taken != pt) || (r.taken && r.target != ptg));
        return r;
    endfunction

    // Apply current inputs for one clock; model the edge, then check registered outputs.
    task automatic tick();
        bit exp_ready, acc, fire;
        #1;
        exp_ready = !mv || out_ready;
        check_eq("in_ready", in_ready, exp_ready);
        if (rst) begin
            mv = 0; mbr = 0; mmis = 0;
        end else begin
            acc  = in_valid && exp_ready && !flush;
            fire = mv && out_ready && !flush;
            if (cnt_clr) begin
                mbr = 0; mmis = 0;
            end else if (fire && mres.cf) begin
                mbr = (mbr + 1 > CMAX) ? CMAX : mbr + 1;
                if (mres.redirect) mmis = (mmis + 1 > CMAX) ? CMAX : mmis + 1;
            end
            if (flush) mv = 0;
            else if (acc) begin
                mres = ref_model(kind, cmp_type, a, b, pc, imm, pred_taken, pred_target);
                mv = 1;
            end else if (fire) mv = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("out_valid", out_valid, mv);
        check_eq("br_cnt", br_cnt, mbr);
        check_eq("mis_cnt", mis_cnt, mmis);
        if (mv) begin
            check_eq("taken", taken, mres.taken);
            check_eq("target", target, mres.target);
            check_eq("link", link, mres.link);
            check_eq("redirect", redirect, mres.redirect);
            check_eq("redirect_pc", redirect_pc, mres.rpc);
            check_eq("illegal", illegal, mres.illegal);
        end
    endtask

    task automatic set_req(input bit [1:0] k, input bit [2:0] t, input bit [31:0] ra,
                           input bit [31:0] rb, input bit [31:0] rp, input bit [31:0] ri,
                           input bit pt, input bit [31:0] ptg);
        in_valid = 1'b1; kind = k; cmp_type = t; a = ra; b = rb; pc = rp; imm = ri;
        pred_taken = pt; pred_target = ptg;
    endtask

    initial begin
        res_t tmp;
        int   saved;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        kind = 2'b00; cmp_type = 3'b000; a = '0; b = '0; pc = '0; imm = '0;
        pred_taken = 1'b0; pred_target = '0;
        mv = 0; mbr = 0; mmis = 0; mres = '{default: 0};
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_taken", taken, 0);
        check_eq("rst_target", target, 0);
        check_eq("rst_link", link, 0);
        check_eq("rst_redirect", redirect, 0);
        check_eq("rst_rpc", redirect_pc, 0);
        check_eq("rst_illegal", illegal, 0);
        rst = 1'b0;

        // Signed vs unsigned less-than on the same operands
        set_req(2'b01, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
        tick();
        check_eq("blt_taken", taken, 1);
        check_eq("blt_target", target, 32'h120);
        check_eq("blt_redirect", redirect, 1);
        check_eq("blt_rpc", redirect_pc, 32'h120);
        cmp_type = 3'b110;
        tick();
        check_eq("bltu_taken", taken, 0);
        check_eq("bltu_redirect", redirect, 0);
        check_eq("bltu_rpc", redirect_pc, 32'h104);

        // JALR target clears bit 0; target prediction matters
        set_req(2'b11, 3'b000, 32'h1003, 32'h0, 32'h40, 32'h2, 1'b1, 32'h1004);
        tick();
        check_eq("jalr_target", target, 32'h1004);
        check_eq("jalr_link", link, 32'h44);
        check_eq("jalr_redirect", redirect, 0);
        pred_target = 32'h1000;
        tick();
        check_eq("jalr_mispred", redirect, 1);
        in_valid = 1'b0;
        tick();

        // Backpressure: second request waits while the first is held
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        out_ready = 1'b0;
        set_req(2'b01, 3'b000, 32'h7, 32'h7, 32'h200, 32'h10, 1'b1, 32'h210);
        tick();
        set_req(2'b10, 3'b000, 32'h0, 32'h0, 32'h300, 32'h40, 1'b1, 32'h340);
        tick();
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_hold_target", target, 32'h210);
        out_ready = 1'b1;
        tick();
        check_eq("bp_cnt1", br_cnt, 1);
        check_eq("bp_second", target, 32'h340);
        in_valid = 1'b0;
        tick();
        check_eq("bp_cnt2", br_cnt, 2);

        // Flush with a held result and a new request in the same cycle
        out_ready = 1'b0;
        set_req(2'b01, 3'b001, 32'h1, 32'h2, 32'h400, 32'h8, 1'b0, 32'h0);
        tick();
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_cnt", br_cnt, 2);
        tick();

        // Illegal compare code, then a NONE beat leaves the counter alone
        set_req(2'b01, 3'b010, 32'h5, 32'h5, 32'h500, 32'h4, 1'b0, 32'h0);
        tick();
        check_eq("ill_illegal", illegal, 1);
        check_eq("ill_taken", taken, 0);
        in_valid = 1'b0; tick();
        saved = br_cnt;
        set_req(2'b00, 3'b000, 32'h5, 32'h5, 32'h600, 32'h4, 1'b1, 32'h0);
        tick();
        in_valid = 1'b0; tick();
        check_eq("none_cnt", br_cnt, saved);

        // Counter saturation and clear beating a simultaneous fire
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        set_req(2'b01, 3'b000, 32'h9, 32'h9, 32'h700, 32'h4, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        in_valid = 1'b0; tick();
        check_eq("sat_br", br_cnt, 15);
        check_eq("sat_mis", mis_cnt, 15);
        set_req(2'b10, 3'b000, 32'h0, 32'h0, 32'h800, 32'h4, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_eq("clr_br", br_cnt, 0);
        check_eq("clr_mis", mis_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            kind      = 2'($urandom_range(0, 3));
            cmp_type  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {1'b1, 31'($urandom_range(0, 7))};
            pc  = $urandom;
            imm = $urandom;
            pred_taken = 1'($urandom_range(0, 1));
            tmp = ref_model(kind, cmp_type, a, b, pc, imm, 1'b0, 32'h0);
            pred_target = ($urandom_range(0, 1) == 1) ? tmp.target : $urandom;
            tick();
        end
        rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
